// File: rtl/spram_be_clr_pkg.sv
// Shared types for the byte-enable single-port RAM with clear sequencer.
package ram_pkg;

  typedef enum logic {
    RDW_READ_FIRST,
    RDW_WRITE_FIRST
  } rdw_mode_e;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } clr_state_e;

endpackage

// File: rtl/spram_be_core.sv
// Behavioural single-port array: byte-lane write merge, read-during-write mux, 1-cycle read.
// Swapped for a foundry macro on ASIC; keep the port contract minimal.
module spram_be_core
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned BYTE_W     = 8,
  parameter rdw_mode_e   RDW_MODE   = RDW_READ_FIRST
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr,
  input  logic                         rd,
  input  logic [DATA_WIDTH/BYTE_W-1:0] be,
  input  logic [$clog2(DEPTH)-1:0]     addr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic                         rvalid
);

  localparam int unsigned NB = DATA_WIDTH / BYTE_W;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged_word;

  // Lanes with be clear keep the stored byte.
  always_comb begin
    old_word    = mem[addr];
    merged_word = old_word;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) begin
        merged_word[i*BYTE_W +: BYTE_W] = wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[addr] <= merged_word;
    end
  end

  // Output captures only on a user access, so rdata holds across idle and sweep cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd;
      if (rd) begin
        if (wr && (RDW_MODE == RDW_WRITE_FIRST)) begin
          rdata <= merged_word;
        end else begin
          rdata <= old_word;
        end
      end
    end
  end

endmodule

// File: rtl/spram_be_clr.sv
// Parametrised single-port RAM with byte enables, optional output register and a
// built-in clear sweep that fills every entry with CLR_VALUE after reset or on request.
module spram_be_clr
  import ram_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 256,
  parameter int unsigned           BYTE_W     = 8,
  parameter int unsigned           OUT_REG    = 0,
  parameter rdw_mode_e             RDW_MODE   = RDW_READ_FIRST,
  parameter int unsigned           CLR_ON_RST = 1,
  parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         we,
  input  logic [DATA_WIDTH/BYTE_W-1:0] be,
  input  logic [$clog2(DEPTH)-1:0]     addr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic                         rvalid,
  input  logic                         clr_req,
  output logic                         busy
);

  localparam int unsigned NB = DATA_WIDTH / BYTE_W;
  localparam int unsigned AW = $clog2(DEPTH);

  clr_state_e state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;

  logic                  core_wr;
  logic                  core_rd;
  logic [NB-1:0]         core_be;
  logic [AW-1:0]         core_addr;
  logic [DATA_WIDTH-1:0] core_wdata;
  logic [DATA_WIDTH-1:0] core_rdata;
  logic                  core_rvalid;

  // Sweep state and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (CLR_ON_RST != 0) ? S_CLEAR : S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (clr_req) begin
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (cnt == AW'(DEPTH - 1)) begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + AW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (state == S_CLEAR);

  // The sweep owns the array while busy; user requests are dropped, not queued.
  always_comb begin
    core_wr    = en & we;
    core_rd    = en;
    core_be    = be;
    core_addr  = addr;
    core_wdata = wdata;
    if (busy) begin
      core_wr    = 1'b1;
      core_rd    = 1'b0;
      core_be    = '1;
      core_addr  = cnt;
      core_wdata = CLR_VALUE;
    end
  end

  spram_be_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .BYTE_W     (BYTE_W),
    .RDW_MODE   (RDW_MODE)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .wr     (core_wr),
    .rd     (core_rd),
    .be     (core_be),
    .addr   (core_addr),
    .wdata  (core_wdata),
    .rdata  (core_rdata),
    .rvalid (core_rvalid)
  );

  if (OUT_REG != 0) begin : g_oreg
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata  <= '0;
        rvalid <= 1'b0;
      end else begin
        rvalid <= core_rvalid;
        if (core_rvalid) begin
          rdata <= core_rdata;
        end
      end
    end
  end else begin : g_noreg
    assign rdata  = core_rdata;
    assign rvalid = core_rvalid;
  end

endmodule

// File: tb/tb_spram_be_clr.sv
// Directed bench for spram_be_clr: two instances (latency 1 / READ_FIRST and latency 2 / WRITE_FIRST)
// share stimulus; a reference array feeds per-instance expected-read queues.
module tb_spram_be_clr;
  import ram_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned NB    = 4;
  localparam int unsigned AW    = 8;

  logic          clk = 1'b0;
  logic          rst, en, we, clr_req;
  logic [NB-1:0] be;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata0, rdata1;
  logic          rvalid0, rvalid1, busy0, busy1;

  always #5 clk = ~clk;

  spram_be_clr #(.OUT_REG(0), .RDW_MODE(RDW_READ_FIRST)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .rdata(rdata0), .rvalid(rvalid0), .clr_req(clr_req), .busy(busy0)
  );

  spram_be_clr #(.OUT_REG(1), .RDW_MODE(RDW_WRITE_FIRST)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .rvalid(rvalid1), .clr_req(clr_req), .busy(busy1)
  );

  typedef struct {
    int            cyc;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  logic [DW-1:0] m [DEPTH];
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  logic          mon_on = 1'b0;
  exp_t          e0, e1;
  logic          ev0, ev1;
  int            n;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected reads are pushed at issue and retired when the cycle number comes due.
  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      ev0 = (q0.size() > 0) && (q0[0].cyc == cyc);
      check("rvalid0", DW'(rvalid0), DW'(ev0));
      if (ev0) begin
        e0 = q0.pop_front();
        check("rdata0", rdata0, e0.d);
      end
      ev1 = (q1.size() > 0) && (q1[0].cyc == cyc);
      check("rvalid1", DW'(rvalid1), DW'(ev1));
      if (ev1) begin
        e1 = q1.pop_front();
        check("rdata1", rdata1, e1.d);
      end
    end
  end

  task automatic access(input logic w, input logic [NB-1:0] b, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    logic [DW-1:0] old_w, new_w;
    old_w = m[a];
    new_w = old_w;
    for (int i = 0; i < int'(NB); i++) begin
      if (w && b[i]) new_w[i*8 +: 8] = d[i*8 +: 8];
    end
    en = 1'b1; we = w; be = b; addr = a; wdata = d;
    q0.push_back('{cyc + 1, old_w});
    q1.push_back('{cyc + 2, new_w});
    m[a] = new_w;
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    en = 1'b0; we = 1'b0; be = '0; clr_req = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  // Counts consecutive busy samples starting at the current negedge.
  task automatic count_busy(output int cnt_o);
    cnt_o = 0;
    for (int k = 0; k < 2000 && busy0 === 1'b1; k++) begin
      cnt_o++;
      @(negedge clk);
    end
    m = '{default: '0};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0; clr_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mon_on = 1'b1;
    check("rst_rdata0", rdata0, '0);
    check("rst_rdata1", rdata1, '0);
    check("rst_busy0", DW'(busy0), DW'(1));
    check("rst_busy1", DW'(busy1), DW'(1));
    count_busy(n);
    check("rst_sweep_cycles", DW'(n), DW'(256));

    // Post-sweep contents are zero.
    access(1'b0, 4'h0, 8'h00, '0);
    access(1'b0, 4'h0, 8'h7F, '0);
    access(1'b0, 4'h0, 8'hFF, '0);
    idle(3);

    // Byte-lane merge, then be==0 no-op write.
    access(1'b1, 4'hF, 8'h10, 32'hDEADBEEF);
    access(1'b1, 4'h5, 8'h10, 32'h11223344);
    access(1'b0, 4'h0, 8'h10, '0);
    access(1'b1, 4'h0, 8'h10, 32'hFFFFFFFF);
    access(1'b0, 4'h0, 8'h10, '0);
    idle(3);
    check("merge_model", m[8'h10], 32'hDE22BE44);

    // Read-during-write: instance 0 sees the old word, instance 1 the new one.
    access(1'b1, 4'hF, 8'h05, 32'hAAAAAAAA);
    access(1'b1, 4'hF, 8'h05, 32'h55555555);
    access(1'b0, 4'h0, 8'h05, '0);
    idle(3);

    // Back-to-back reads on consecutive cycles.
    access(1'b1, 4'hF, 8'h01, 32'h01010101);
    access(1'b1, 4'hF, 8'h02, 32'h02020202);
    access(1'b1, 4'hF, 8'h03, 32'h03030303);
    access(1'b0, 4'h0, 8'h01, '0);
    access(1'b0, 4'h0, 8'h02, '0);
    access(1'b0, 4'h0, 8'h03, '0);
    idle(4);
    check("hold_rdata0", rdata0, 32'h03030303);
    check("hold_rdata1", rdata1, 32'h03030303);

    // Requested sweep; clr_req and accesses during it must be ignored.
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    n = 0;
    for (int k = 0; k < 2000 && busy0 === 1'b1; k++) begin
      n++;
      clr_req = (k == 10) || (k == 255);
      en      = (k >= 40) && (k < 60);
      we      = k[0];
      be      = '1;
      addr    = AW'(k - 40);
      wdata   = 32'hFFFFFFFF;
      @(negedge clk);
    end
    idle(0);
    m = '{default: '0};
    check("req_sweep_cycles", DW'(n), DW'(256));
    for (int a = 0; a < 20; a++) access(1'b0, 4'h0, AW'(a), '0);
    idle(3);

    // Reset part-way through a sweep restarts a full one and clears rdata.
    access(1'b1, 4'hF, 8'h09, 32'hCAFEF00D);
    access(1'b0, 4'h0, 8'h09, '0);
    idle(3);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_rdata0", rdata0, '0);
    check("midrst_rdata1", rdata1, '0);
    check("midrst_busy", DW'(busy0), DW'(1));
    count_busy(n);
    check("midrst_sweep_cycles", DW'(n), DW'(256));

    // Same-cycle clr_req and write: write lands, sweep starts next cycle and wipes it.
    clr_req = 1'b1;
    access(1'b1, 4'hF, 8'h03, 32'h12345678);
    idle(0);
    check("clr_wr_busy0", DW'(busy0), DW'(1));
    check("clr_wr_busy1", DW'(busy1), DW'(1));
    count_busy(n);
    check("clr_wr_sweep_cycles", DW'(n), DW'(256));
    access(1'b0, 4'h0, 8'h03, '0);
    access(1'b0, 4'h0, 8'h09, '0);
    idle(5);

    check("q0_drained", DW'(q0.size()), '0);
    check("q1_drained", DW'(q1.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
